tile_renderer: RTL and testbench
================================

Name: tile_renderer

Overview:
- Parametrised successor to the fixed 16x12 tank-tile drawer.
- Accepts one grid cell (cell address + cell content byte) through a start/ready handshake, then raster-scans the whole tile.
- Emits one pixel (x, y, colour, plot) per clock to the VGA adapter, then pulses done.
- Every pixel of the tile is written: background where nothing is drawn, so stale sprites are erased. Tank body, direction-dependent gun barrel, projectile and wall sprites are all supported.

Parameters:
- TILE_W, 16, tile width in pixels; must be >= 12
- TILE_H, 12, tile height in pixels; must be >= 12
- COL_BITS, 4, cell address bits [COL_BITS-1:0] select the grid column
- ROW_BITS, 4, cell address bits [COL_BITS+ROW_BITS-1:COL_BITS] select the grid row
- X_W, 8, screen x width
- Y_W, 7, screen y width
- COLOUR_W, 3, colour width

Ports:
- clock  in  1  system clock, 50 MHz
- resetn  in  1  asynchronous, active-low reset
- start  in  1  request to render a cell; accepted only while ready=1
- address  in  COL_BITS+ROW_BITS  cell address
- position  in  8  cell content: bit7 wall, bit6 tank1, bit5 tank2, bit4 projectile, bits1:0 direction (00 up, 01 down, 10 left, 11 right)
- ready  out  1  idle and able to accept start
- plot  out  1  x/y/colour valid; write enable to the VGA adapter
- x  out  X_W  pixel x
- y  out  Y_W  pixel y
- colour  out  COLOUR_W  pixel colour
- done  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset (async, resetn=0): state IDLE, ready=1, plot=0, done=0, x=0, y=0, colour=0, scan counters 0. Reset mid-render aborts immediately; no done pulse.
- States:
  - IDLE: ready=1. On start=1, latch address and position, clear px/py, go to SCAN.
  - SCAN: ready=0. One pixel per cycle, row-major: px 0..TILE_W-1, then py++. After px=TILE_W-1 and py=TILE_H-1, go to DONE.
  - DONE: one cycle; done=1, plot=0, ready=1. A start seen in this cycle is accepted, going straight to SCAN.
- Timing: start accepted at edge k. plot=1 during cycles k+1 .. k+N, with N = TILE_W*TILE_H (192 by default). done=1 in cycle k+N+1.
- start while ready=0 is ignored; latched inputs do not change during a render.
- All outputs are registered.
- Coordinates: x = col*TILE_W + px, y = row*TILE_H + py, truncated to X_W/Y_W. The caller keeps the tile inside the 160x120 screen (default: col <= 9, row <= 9); wrap on overflow is not checked.
- Geometry, with CX=TILE_W/2 and CY=TILE_H/2; all ranges are inclusive:
  - Body: px CX-4..CX+3, py CY-4..CY+3
  - Barrel up: px CX-1..CX, py CY-6..CY-5
  - Barrel down: px CX-1..CX, py CY+4..CY+5
  - Barrel left: px CX-6..CX-5, py CY-1..CY
  - Barrel right: px CX+4..CX+5, py CY-1..CY
  - Projectile: px CX-1..CX, py CY-1..CY
- Colour priority (first match wins):
  - wall: whole tile COL_WALL (111)
  - tank1: body+barrel COL_TANK1 (001), else COL_BG
  - tank2: body+barrel COL_TANK2 (010), else COL_BG
  - projectile: projectile square COL_PROJ (110), else COL_BG
  - otherwise: COL_BG (000)
- Direction bits are ignored for wall, projectile and empty cells.

Decomposition:
- Shared package tank_pkg:
  - content bit indices WALL_BIT=7, TANK1_BIT=6, TANK2_BIT=5, PROJ_BIT=4
  - direction codes DIR_UP/DOWN/LEFT/RIGHT
  - colour constants COL_BG, COL_WALL, COL_TANK1, COL_TANK2, COL_PROJ
- Sub-module tile_scan_counter:
  - px/py raster counter with clear, enable and last-pixel flag
  - parameterised by TILE_W and TILE_H
- Sprite hit test and colour priority live in tile_renderer.

Test Plan:
1. Reset: resetn=0 -> ready=1, plot=0, done=0, x=y=colour=0. Assert resetn low at pixel 50 of a render -> plot=0 and ready=1 immediately, no done.
2. address=8'h00, position=8'h00 -> 192 plot cycles, colour 000, first pixel (0,0), last (15,11); done exactly at cycle 193 after acceptance.
3. address=8'h23 (row 2, col 3), position=8'h80 -> 192 pixels at colour 111, x 48..63, y 24..35; last pixel (63,35).
4. address=8'h00, position=8'h43 (tank1, right) -> (12,5)=001, (13,6)=001, (2,5)=000, (4,2)=001, (3,2)=000; exactly 68 pixels at 001. Repeat with position=8'h60 -> tank1 colour wins over tank2, barrel up at (7,0) and (8,1).
5. position=8'h10 -> exactly 4 pixels at 110: (7,5), (8,5), (7,6), (8,6); all others 000.
6. start pulsed mid-SCAN with a different address -> ignored, original tile completes. start held high through done -> second render begins at done cycle+1 with no gap.

Source files
------------

// File: rtl/tank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tank_pkg
//  Description : Shared definitions for the tank-game tile renderer: cell
//                content bit positions, direction codes, palette, FSM states
//                and a small range helper for sprite hit tests.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
package tank_pkg;

    // Bit positions inside the cell content byte
    localparam int WALL_BIT  = 7;
    localparam int TANK1_BIT = 6;
    localparam int TANK2_BIT = 5;
    localparam int PROJ_BIT  = 4;

    // Gun barrel direction, taken from content bits 1:0
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    // Palette
    localparam logic [2:0] COL_BG    = 3'b000;
    localparam logic [2:0] COL_WALL  = 3'b111;
    localparam logic [2:0] COL_TANK1 = 3'b001;
    localparam logic [2:0] COL_TANK2 = 3'b010;
    localparam logic [2:0] COL_PROJ  = 3'b110;

    // Renderer control states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Decoded cell content; only the fields the renderer acts on
    typedef struct packed {
        logic wall;
        logic tank1;
        logic tank2;
        logic proj;
        dir_t dir;
    } cell_t;

    // Inclusive range test used by every sprite rectangle
    function automatic logic in_range(input int v, input int lo, input int hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tile_scan_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tile_scan_counter
//  Description : Row-major px/py raster counter over one tile. Exposes the
//                coordinates that follow the current pixel and a flag that
//                marks the final pixel of the tile.
//  Revision    : 1.0  initial release
// ============================================================================
module tile_scan_counter #(
    parameter int TILE_W = 16,
    parameter int TILE_H = 12,
    parameter int PX_W   = $clog2(TILE_W),
    parameter int PY_W   = $clog2(TILE_H)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            i_clear,
    input  logic            i_enable,
    output logic [PX_W-1:0] o_nxt_px,
    output logic [PY_W-1:0] o_nxt_py,
    output logic            o_last
);

    logic [PX_W-1:0] r_px;
    logic [PY_W-1:0] r_py;
    logic            w_px_wrap;
    logic            w_py_wrap;

    // Successor coordinates and end-of-tile detection
    always_comb begin
        w_px_wrap = (r_px == PX_W'(TILE_W - 1));
        w_py_wrap = (r_py == PY_W'(TILE_H - 1));
        o_last    = w_px_wrap && w_py_wrap;
        o_nxt_px  = w_px_wrap ? '0 : r_px + PX_W'(1);
        if (w_px_wrap) begin
            o_nxt_py = w_py_wrap ? '0 : r_py + PY_W'(1);
        end else begin
            o_nxt_py = r_py;
        end
    end

    // Counter register: clear wins over advance
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_px <= '0;
            r_py <= '0;
        end else if (i_clear) begin
            r_px <= '0;
            r_py <= '0;
        end else if (i_enable) begin
            r_px <= o_nxt_px;
            r_py <= o_nxt_py;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tile_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tile_renderer
//  Description : Accepts one grid cell through a start/ready handshake and
//                raster-scans the whole tile, emitting one registered pixel
//                per clock (background, wall, tank body + barrel, projectile)
//                to the VGA adapter, then pulses done.
//  Revision    : 1.0  initial parametrised release
// ============================================================================
module tile_renderer
    import tank_pkg::*;
#(
    parameter int TILE_W   = 16,
    parameter int TILE_H   = 12,
    parameter int COL_BITS = 4,
    parameter int ROW_BITS = 4,
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int COLOUR_W = 3
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic                         start,
    input  logic [COL_BITS+ROW_BITS-1:0] address,
    input  logic [7:0]                   position,
    output logic                         ready,
    output logic                         plot,
    output logic [X_W-1:0]               x,
    output logic [Y_W-1:0]               y,
    output logic [COLOUR_W-1:0]          colour,
    output logic                         done
);

    localparam int ADDR_W = COL_BITS + ROW_BITS;
    localparam int PX_W   = $clog2(TILE_W);
    localparam int PY_W   = $clog2(TILE_H);
    localparam int CX     = TILE_W / 2;
    localparam int CY     = TILE_H / 2;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    cell_t             r_cell;
    cell_t             w_in_cell;

    logic              w_accept;
    logic              w_advance;
    logic              w_emit;
    logic [PX_W-1:0]   w_nxt_px;
    logic [PY_W-1:0]   w_nxt_py;
    logic              w_last;

    logic [ADDR_W-1:0] w_src_addr;
    cell_t             w_src_cell;
    logic [PX_W-1:0]   w_src_px;
    logic [PY_W-1:0]   w_src_py;
    int                w_px_i;
    int                w_py_i;
    logic              w_body;
    logic              w_barrel;
    logic              w_proj;
    logic [2:0]        w_colour;
    logic [X_W-1:0]    w_x;
    logic [Y_W-1:0]    w_y;
    logic              w_unused_pos;

    // Reserved content bits carry no meaning for drawing
    assign w_unused_pos = &{1'b0, position[3:2]};

    assign w_in_cell = '{
        wall:  position[WALL_BIT],
        tank1: position[TANK1_BIT],
        tank2: position[TANK2_BIT],
        proj:  position[PROJ_BIT],
        dir:   dir_t'(position[1:0])
    };

    // A request is taken whenever we are not mid-scan (IDLE or DONE)
    assign w_accept  = start && (r_state != ST_SCAN);
    assign w_advance = (r_state == ST_SCAN) && !w_last;
    assign w_emit    = w_accept || w_advance;

    tile_scan_counter #(
        .TILE_W (TILE_W),
        .TILE_H (TILE_H),
        .PX_W   (PX_W),
        .PY_W   (PY_W)
    ) u_scan (
        .clock    (clock),
        .resetn   (resetn),
        .i_clear  (w_accept),
        .i_enable (w_advance),
        .o_nxt_px (w_nxt_px),
        .o_nxt_py (w_nxt_py),
        .o_last   (w_last)
    );

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start)  w_state_nxt = ST_SCAN;
            ST_SCAN: if (w_last) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = start ? ST_SCAN : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Capture the cell on acceptance; held constant for the whole scan
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr <= '0;
            r_cell <= '0;
        end else if (w_accept) begin
            r_addr <= address;
            r_cell <= w_in_cell;
        end
    end

    // Pixel about to be registered: the first pixel comes straight from the
    // request so plot can rise the cycle after acceptance
    always_comb begin
        w_src_addr = w_accept ? address   : r_addr;
        w_src_cell = w_accept ? w_in_cell : r_cell;
        w_src_px   = w_accept ? '0        : w_nxt_px;
        w_src_py   = w_accept ? '0        : w_nxt_py;
        w_x = X_W'(32'(w_src_addr[COL_BITS-1:0]) * TILE_W + 32'(w_src_px));
        w_y = Y_W'(32'(w_src_addr[ADDR_W-1:COL_BITS]) * TILE_H + 32'(w_src_py));
    end

    // Sprite hit test and colour priority
    always_comb begin
        w_px_i   = int'(w_src_px);
        w_py_i   = int'(w_src_py);
        w_body   = in_range(w_px_i, CX - 4, CX + 3) && in_range(w_py_i, CY - 4, CY + 3);
        w_proj   = in_range(w_px_i, CX - 1, CX)     && in_range(w_py_i, CY - 1, CY);
        w_barrel = 1'b0;
        case (w_src_cell.dir)
            DIR_UP:    w_barrel = in_range(w_px_i, CX - 1, CX)     && in_range(w_py_i, CY - 6, CY - 5);
            DIR_DOWN:  w_barrel = in_range(w_px_i, CX - 1, CX)     && in_range(w_py_i, CY + 4, CY + 5);
            DIR_LEFT:  w_barrel = in_range(w_px_i, CX - 6, CX - 5) && in_range(w_py_i, CY - 1, CY);
            DIR_RIGHT: w_barrel = in_range(w_px_i, CX + 4, CX + 5) && in_range(w_py_i, CY - 1, CY);
            default:   w_barrel = 1'b0;
        endcase

        w_colour = COL_BG;
        if (w_src_cell.wall) begin
            w_colour = COL_WALL;
        end else if (w_src_cell.tank1) begin
            w_colour = (w_body || w_barrel) ? COL_TANK1 : COL_BG;
        end else if (w_src_cell.tank2) begin
            w_colour = (w_body || w_barrel) ? COL_TANK2 : COL_BG;
        end else if (w_src_cell.proj) begin
            w_colour = w_proj ? COL_PROJ : COL_BG;
        end
    end

    // Registered handshake/status outputs follow the next state
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready <= 1'b1;
            plot  <= 1'b0;
            done  <= 1'b0;
        end else begin
            ready <= (w_state_nxt != ST_SCAN);
            plot  <= (w_state_nxt == ST_SCAN);
            done  <= (w_state_nxt == ST_DONE);
        end
    end

    // Registered pixel outputs; hold their last value between renders
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            x      <= '0;
            y      <= '0;
            colour <= '0;
        end else if (w_emit) begin
            x      <= w_x;
            y      <= w_y;
            colour <= COLOUR_W'(w_colour);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tile_renderer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_renderer
//  Description : Directed, table-driven bench for tile_renderer with
//                hand-computed pixel expectations and a few multi-cycle
//                handshake/reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tile_renderer;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [7:0] address;
    logic [7:0] position;
    logic       ready;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       done;

    int n_checks;
    int n_fail;

    // Capture of the most recent render
    logic [2:0] tile [0:11][0:15];
    int n_plot, done_cyc, n_out, n_order;
    int first_x, first_y, last_x, last_y;

    tile_renderer dut (
        .clock    (clk),
        .resetn   (resetn),
        .start    (start),
        .address  (address),
        .position (position),
        .ready    (ready),
        .plot     (plot),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int count_col(input logic [2:0] c);
        int n = 0;
        for (int r = 0; r < 12; r++)
            for (int q = 0; q < 16; q++)
                if (tile[r][q] === c) n++;
        return n;
    endfunction

    // Issue one request and record every plotted pixel until done (bounded)
    task automatic render(input logic [7:0] a, input logic [7:0] p, input int poke, input bit hold);
        int col, row, lx, ly;
        col = int'(a[3:0]);
        row = int'(a[7:4]);
        for (int r = 0; r < 12; r++)
            for (int q = 0; q < 16; q++)
                tile[r][q] = 3'b101;
        n_plot = 0; done_cyc = -1; n_out = 0; n_order = 0;
        first_x = -1; first_y = -1; last_x = -1; last_y = -1;
        @(negedge clk);
        address = a; position = p; start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (plot) begin
                lx = int'(x) - col * 16;
                ly = int'(y) - row * 12;
                if (n_plot == 0) begin first_x = int'(x); first_y = int'(y); end
                last_x = int'(x); last_y = int'(y);
                if (lx < 0 || lx > 15 || ly < 0 || ly > 11) begin
                    n_out++;
                end else begin
                    tile[ly][lx] = colour;
                    if (lx != n_plot % 16 || ly != n_plot / 16) n_order++;
                end
                n_plot++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == poke) begin
                start = 1'b1; address = 8'h55; position = 8'h80;
            end else if (cyc == poke + 1 && !hold) begin
                start = 1'b0; address = a; position = p;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] pos;
        int         px;
        int         py;
        logic [2:0] col;
    } probe_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] pos;
        logic [2:0] col;
        int         cnt;
    } count_t;

    probe_t probes [20];
    count_t counts [7];

    initial begin
        logic [7:0] cur_a, cur_p;
        bit   have;
        int   seen_done, seen_plot, extra;

        n_checks = 0; n_fail = 0;
        resetn = 1'b0; start = 1'b0; address = 8'h00; position = 8'h00;

        probes[0]  = '{8'h00, 8'h43, 12, 5, 3'b001};
        probes[1]  = '{8'h00, 8'h43, 13, 6, 3'b001};
        probes[2]  = '{8'h00, 8'h43,  2, 5, 3'b000};
        probes[3]  = '{8'h00, 8'h43,  4, 2, 3'b001};
        probes[4]  = '{8'h00, 8'h43,  3, 2, 3'b000};
        probes[5]  = '{8'h00, 8'h43, 11, 9, 3'b001};
        probes[6]  = '{8'h00, 8'h43, 14, 5, 3'b000};
        probes[7]  = '{8'h00, 8'h60,  7, 0, 3'b001};
        probes[8]  = '{8'h00, 8'h60,  8, 1, 3'b001};
        probes[9]  = '{8'h00, 8'h60, 12, 5, 3'b000};
        probes[10] = '{8'h00, 8'h60,  6, 0, 3'b000};
        probes[11] = '{8'h00, 8'h10,  7, 5, 3'b110};
        probes[12] = '{8'h00, 8'h10,  8, 6, 3'b110};
        probes[13] = '{8'h00, 8'h10,  6, 5, 3'b000};
        probes[14] = '{8'h00, 8'h10,  9, 6, 3'b000};
        probes[15] = '{8'h11, 8'h21,  4, 2, 3'b010};
        probes[16] = '{8'h11, 8'h21,  8, 11, 3'b010};
        probes[17] = '{8'h11, 8'h21,  7, 0, 3'b000};
        probes[18] = '{8'h00, 8'h42,  2, 6, 3'b001};
        probes[19] = '{8'h00, 8'h42,  1, 6, 3'b000};

        counts[0] = '{8'h00, 8'h00, 3'b000, 192};
        counts[1] = '{8'h23, 8'h80, 3'b111, 192};
        counts[2] = '{8'h00, 8'h43, 3'b001, 68};
        counts[3] = '{8'h00, 8'h60, 3'b001, 68};
        counts[4] = '{8'h00, 8'h10, 3'b110, 4};
        counts[5] = '{8'h00, 8'h10, 3'b000, 188};
        counts[6] = '{8'h00, 8'h93, 3'b111, 192};

        // Reset state
        #12;
        chk("rst_ready", int'(ready), 1);
        chk("rst_plot", int'(plot), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_colour", int'(colour), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Blank tile: timing and raster order
        render(8'h00, 8'h00, 0, 1'b0);
        chk("blank_plots", n_plot, 192);
        chk("blank_done_cyc", done_cyc, 193);
        chk("blank_first_x", first_x, 0);
        chk("blank_first_y", first_y, 0);
        chk("blank_last_x", last_x, 15);
        chk("blank_last_y", last_y, 11);
        chk("blank_order", n_order, 0);

        // Wall tile at row 2, col 3
        render(8'h23, 8'h80, 0, 1'b0);
        chk("wall_plots", n_plot, 192);
        chk("wall_out", n_out, 0);
        chk("wall_first_x", first_x, 48);
        chk("wall_first_y", first_y, 24);
        chk("wall_last_x", last_x, 63);
        chk("wall_last_y", last_y, 35);

        // Per-pixel probes
        have = 1'b0; cur_a = '0; cur_p = '0;
        for (int i = 0; i < 20; i++) begin
            if (!have || cur_a != probes[i].addr || cur_p != probes[i].pos) begin
                render(probes[i].addr, probes[i].pos, 0, 1'b0);
                cur_a = probes[i].addr; cur_p = probes[i].pos; have = 1'b1;
                chk($sformatf("probe%0d_plots", i), n_plot, 192);
                chk($sformatf("probe%0d_done", i), done_cyc, 193);
                chk($sformatf("probe%0d_out", i), n_out, 0);
            end
            chk($sformatf("probe%0d_pix_%0d_%0d", i, probes[i].px, probes[i].py),
                int'(tile[probes[i].py][probes[i].px]), int'(probes[i].col));
        end

        // Colour population counts
        for (int i = 0; i < 7; i++) begin
            render(counts[i].addr, counts[i].pos, 0, 1'b0);
            chk($sformatf("count%0d_col%0d", i, counts[i].col),
                count_col(counts[i].col), counts[i].cnt);
        end

        // start mid-scan is ignored
        render(8'h12, 8'h00, 20, 1'b0);
        chk("poke_plots", n_plot, 192);
        chk("poke_out", n_out, 0);
        chk("poke_done", done_cyc, 193);
        @(negedge clk);
        chk("poke_idle_plot", int'(plot), 0);
        chk("poke_idle_ready", int'(ready), 1);

        // start held high through done: back-to-back renders
        render(8'h01, 8'h00, 0, 1'b1);
        chk("hold_done", done_cyc, 193);
        chk("hold_ready_at_done", int'(ready), 1);
        @(negedge clk);
        start = 1'b0;
        chk("hold_nogap_plot", int'(plot), 1);
        chk("hold_nogap_x", int'(x), 16);
        chk("hold_nogap_y", int'(y), 0);
        extra = 1; seen_done = 0;
        for (int c = 0; c < 300 && seen_done == 0; c++) begin
            @(negedge clk);
            if (plot) extra++;
            if (done) seen_done = 1;
        end
        chk("hold_second_plots", extra, 192);
        chk("hold_second_done", seen_done, 1);

        // Reset at pixel 50 of a render aborts immediately
        @(negedge clk);
        address = 8'h00; position = 8'h40; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_plot = 0;
        for (int c = 0; c < 300 && seen_plot < 50; c++) begin
            if (plot) seen_plot++;
            if (seen_plot < 50) @(negedge clk);
        end
        chk("abort_reached_50", seen_plot, 50);
        #2;
        resetn = 1'b0;
        #1;
        chk("abort_plot", int'(plot), 0);
        chk("abort_ready", int'(ready), 1);
        chk("abort_done", int'(done), 0);
        chk("abort_colour", int'(colour), 0);
        @(negedge clk);
        resetn = 1'b1;
        seen_done = 0; seen_plot = 0;
        for (int c = 0; c < 250; c++) begin
            @(negedge clk);
            if (done) seen_done++;
            if (plot) seen_plot++;
        end
        chk("abort_no_done", seen_done, 0);
        chk("abort_no_plot", seen_plot, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
